// File: rtl/dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : dmem_arbiter                                                |
// | Purpose  : Shares a single-port data memory between the core load/     |
// |            store port and a debug/loader port. Core has priority; a    |
// |            starvation counter bounds how long debug can be locked out. |
// |            Memory commands are registered; the core is stalled until   |
// |            its own access completes.                                   |
// | Options  : DMEM_ARB_PERF_EN adds the stall_cycles performance counter. |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_rd,
  input  logic              c_wr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_stall,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_rd,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] LAT_INIT   = 2'(RD_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic       OWN_CORE   = 1'b0;
  localparam logic       OWN_DBG    = 1'b1;

  state_t            state_q, state_d;
  logic [1:0]        lat_q, lat_d;
  logic [3:0]        starve_q, starve_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              m_rd_q, m_rd_d;
  logic              m_wr_q, m_wr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic core_req;
  logic dbg_wins;
  logic complete;

  assign core_req = c_rd | c_wr;
  // Debug wins when the core is idle or has used up its consecutive grants.
  assign dbg_wins = d_req & (~core_req | (starve_q == STARVE_LIM));
  // Writes finish in ISSUE, reads in DONE.
  assign complete = ((state_q == S_ISSUE) & we_q) | (state_q == S_DONE);

  assign c_stall = core_req & ~(complete & (owner_q == OWN_CORE));
  assign d_gnt   = complete & (owner_q == OWN_DBG);
  assign m_rd    = m_rd_q;
  assign m_wr    = m_wr_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;

  // Next-state logic: arbitration, command latching and read capture.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    starve_d  = starve_q;
    owner_d   = owner_q;
    we_d      = we_q;
    m_rd_d    = 1'b0;
    m_wr_d    = 1'b0;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (!d_req) starve_d = '0;
        if (core_req || d_req) begin
          state_d = S_ISSUE;
          if (dbg_wins) begin
            owner_d   = OWN_DBG;
            we_d      = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            starve_d  = '0;
          end else begin
            // Simultaneous c_rd and c_wr is treated as a store.
            owner_d   = OWN_CORE;
            we_d      = c_wr;
            m_addr_d  = c_addr;
            m_wdata_d = c_wdata;
            if (d_req && (starve_q != STARVE_LIM)) starve_d = starve_q + 4'd1;
          end
          m_wr_d = we_d;
          m_rd_d = ~we_d;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          lat_d   = LAT_INIT;
        end
      end
      S_WAIT: begin
        if (lat_q == 2'd0) begin
          state_d = S_DONE;
          if (owner_q == OWN_DBG) d_rdata_d = m_rdata;
          else                    c_rdata_d = m_rdata;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      lat_q     <= '0;
      starve_q  <= '0;
      owner_q   <= OWN_CORE;
      we_q      <= 1'b0;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      starve_q  <= starve_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Count every cycle the core is frozen; wraps naturally at 2^32.
  always_comb stall_cycles_d = c_stall ? stall_cycles_q + 32'd1 : stall_cycles_q;

  // Performance counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_dmem_arbiter                                             |
// | Purpose  : Self-checking bench for dmem_arbiter against a transaction- |
// |            level reference model and a behavioural memory.            |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_dmem_arbiter;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 9;
  localparam int RD_LAT     = 3;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              c_rd, c_wr, c_stall, d_req, d_we, d_gnt, m_rd, m_wr;
  logic [ADDR_W-1:0] c_addr, d_addr, m_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata, d_wdata, d_rdata, m_wdata, m_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]       stall_cycles;
`endif

  dmem_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_stall(c_stall), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata),
    .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Environment memory and the model's own view of it.
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] init_100;
  int                rd_due = -1;
  logic [DATA_W-1:0] rd_val;

  // Transaction-level reference model state.
  int                cyc = 0;
  bit                in_reset;
  bit                t_valid, t_dbg, t_we;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata, t_rdata;
  int                t_strobe, t_done, next_arb, starve;
  logic [DATA_W-1:0] exp_c_rdata, exp_d_rdata;
  bit                core_done_now, dbg_done_now;
  longint            perf_exp;

  // Evaluate one cycle at the falling edge: model, compare, memory response.
  task automatic eval_cycle();
    bit e_mrd, e_mwr, cdone, ddone, creq, e_stall;
    creq  = c_rd | c_wr;
    cdone = 1'b0; ddone = 1'b0; e_mrd = 1'b0; e_mwr = 1'b0;
    if (in_reset) begin
      t_valid = 1'b0; next_arb = cyc + 1; starve = 0;
      exp_c_rdata = '0; exp_d_rdata = '0; rd_due = -1; perf_exp = 0;
      chk_val("rst_m_addr", 64'(m_addr), 64'(0));
      chk_val("rst_m_wdata", 64'(m_wdata), 64'(0));
    end else begin
      if (cyc >= next_arb) begin
        if (!d_req) starve = 0;
        if (creq || d_req) begin
          t_valid = 1'b1;
          t_dbg   = d_req && (!creq || starve == STARVE_MAX);
          if (t_dbg) begin
            t_we = d_we; t_addr = d_addr; t_wdata = d_wdata; starve = 0;
          end else begin
            t_we = c_wr; t_addr = c_addr; t_wdata = c_wdata;
            if (d_req && starve < STARVE_MAX) starve = starve + 1;
          end
          t_strobe = cyc + 1;
          t_done   = t_we ? cyc + 1 : cyc + 2 + RD_LAT;
          next_arb = t_done + 1;
          if (t_we) ref_mem[t_addr] = t_wdata;
          else      t_rdata = ref_mem[t_addr];
        end
      end
      if (t_valid && cyc == t_strobe) begin
        e_mrd = !t_we; e_mwr = t_we;
        chk_val("m_addr", 64'(m_addr), 64'(t_addr));
        if (t_we) chk_val("m_wdata", 64'(m_wdata), 64'(t_wdata));
      end
      if (t_valid && cyc == t_done) begin
        if (t_dbg) begin
          ddone = 1'b1;
          if (!t_we) exp_d_rdata = t_rdata;
        end else begin
          cdone = 1'b1;
          if (!t_we) exp_c_rdata = t_rdata;
        end
        t_valid = 1'b0;
      end
    end
    e_stall = creq && !cdone;
    chk_val("m_rd", 64'(m_rd), 64'(e_mrd));
    chk_val("m_wr", 64'(m_wr), 64'(e_mwr));
    chk_val("c_stall", 64'(c_stall), 64'(e_stall));
    chk_val("d_gnt", 64'(d_gnt), 64'(ddone));
    chk_val("c_rdata", 64'(c_rdata), 64'(exp_c_rdata));
    chk_val("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
`ifdef DMEM_ARB_PERF_EN
    chk_val("stall_cycles", 64'(stall_cycles), 64'(perf_exp[31:0]));
    if (!in_reset && e_stall) perf_exp++;
`endif
    if (m_wr === 1'b1) mem[m_addr] = m_wdata;
    if (m_rd === 1'b1) begin
      rd_due = cyc + RD_LAT;
      rd_val = mem[m_addr];
    end
    m_rdata       = (cyc == rd_due) ? rd_val : $urandom;
    core_done_now = cdone;
    dbg_done_now  = ddone;
    cyc++;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    eval_cycle();
  endtask

  task automatic new_core_req(input bit allow_idle);
    int kind;
    kind = $urandom_range(0, 3);
    if (allow_idle && $urandom_range(0, 99) < 40) begin
      c_rd = 1'b0; c_wr = 1'b0;
    end else begin
      c_rd    = (kind != 1);
      c_wr    = (kind == 1) || (kind == 2);
      c_addr  = ADDR_W'($urandom_range(0, 15));
      c_wdata = $urandom;
    end
  endtask

  task automatic new_dbg_req(input bit allow_idle);
    if (allow_idle && $urandom_range(0, 99) < 70) begin
      d_req = 1'b0;
    end else begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = ADDR_W'($urandom_range(0, 15));
      d_wdata = $urandom;
    end
  endtask

  task automatic core_txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    c_rd = rd; c_wr = wr; c_addr = a; c_wdata = d;
    next_cycle();
    for (int i = 0; i < 20 && !core_done_now; i++) begin
      @(posedge clk); #1;
      next_cycle();
    end
    if (!core_done_now) chk_val("core_txn_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    c_rd = 1'b0; c_wr = 1'b0;
    next_cycle();
  endtask

  task automatic dbg_txn(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = d;
    next_cycle();
    for (int i = 0; i < 20 && !dbg_done_now; i++) begin
      @(posedge clk); #1;
      next_cycle();
    end
    if (!dbg_done_now) chk_val("dbg_txn_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    d_req = 1'b0;
    next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount, ccount;
    bit found;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_start;
    int          reads_done;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    init_100 = mem[9'h100];
    reset = 1'b0; in_reset = 1'b1; m_rdata = '0;
    c_rd = 1'b0; c_wr = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) next_cycle();
    @(posedge clk); #1;
    reset = 1'b1; in_reset = 1'b0;
    next_cycle();

    // Directed: core write, core read-back, lone debug read.
    core_txn(1'b0, 1'b1, 9'h01A, 32'hDEADBEEF);
    core_txn(1'b1, 1'b0, 9'h01A, 32'h0);
    chk_val("core_readback", 64'(c_rdata), 64'(32'hDEADBEEF));
    dbg_txn(1'b0, 9'h100, 32'h0);
    chk_val("dbg_read_100", 64'(d_rdata), 64'(init_100));
    repeat (2) begin @(posedge clk); #1; next_cycle(); end

    // Contention: both requesters always pending, count completions.
    dcount = 0; ccount = 0;
    @(posedge clk); #1;
    new_core_req(1'b0); new_dbg_req(1'b0);
    next_cycle();
    for (int i = 0; i < 400 && (dcount + ccount) < 20; i++) begin
      if (d_gnt === 1'b1) dcount++;
      if (c_stall === 1'b0) ccount++;
      @(posedge clk); #1;
      if (core_done_now) new_core_req(1'b0);
      if (dbg_done_now)  new_dbg_req(1'b0);
      next_cycle();
    end
    chk_val("contend_dbg_grants", 64'(dcount), 64'(20 / (STARVE_MAX + 1)));
    chk_val("contend_core_grants", 64'(ccount), 64'(20 - 20 / (STARVE_MAX + 1)));
    for (int i = 0; i < 20 && (c_rd || c_wr || d_req); i++) begin
      @(posedge clk); #1;
      if (core_done_now) begin c_rd = 1'b0; c_wr = 1'b0; end
      if (dbg_done_now)  d_req = 1'b0;
      next_cycle();
    end

    // Reset during WAIT of a core read; the held request restarts afterwards.
    @(posedge clk); #1;
    c_rd = 1'b1; c_wr = 1'b0; c_addr = 9'h01A;
    next_cycle();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      next_cycle();
      if (t_valid && !t_dbg && (cyc - 1) == t_strobe) found = 1'b1;
    end
    chk_val("reach_wait", 64'(found), 64'(1));
    @(posedge clk); #1;
    reset = 1'b0; in_reset = 1'b1;
    #1;
    chk_val("arst_m_rd", 64'(m_rd), 64'(0));
    chk_val("arst_m_wr", 64'(m_wr), 64'(0));
    chk_val("arst_m_addr", 64'(m_addr), 64'(0));
    chk_val("arst_m_wdata", 64'(m_wdata), 64'(0));
    chk_val("arst_c_rdata", 64'(c_rdata), 64'(0));
    chk_val("arst_d_rdata", 64'(d_rdata), 64'(0));
    chk_val("arst_d_gnt", 64'(d_gnt), 64'(0));
    chk_val("arst_c_stall", 64'(c_stall), 64'(1));
    next_cycle();
    repeat (2) begin @(posedge clk); #1; next_cycle(); end
    @(posedge clk); #1;
    reset = 1'b1; in_reset = 1'b0;
    next_cycle();
    for (int i = 0; i < 20 && !core_done_now; i++) begin
      @(posedge clk); #1;
      next_cycle();
    end
    chk_val("restart_done", 64'(core_done_now), 64'(1));
    chk_val("restart_rdata", 64'(c_rdata), 64'(32'hDEADBEEF));
    @(posedge clk); #1;
    c_rd = 1'b0;
    next_cycle();

`ifdef DMEM_ARB_PERF_EN
    // Ten back-to-back core reads: each stalls for 2+RD_LAT cycles.
    @(posedge clk); #1;
    c_rd = 1'b1; c_wr = 1'b0; c_addr = 9'h003;
    perf_start = stall_cycles;
    reads_done = 0;
    next_cycle();
    for (int i = 0; i < 200 && reads_done < 10; i++) begin
      if (core_done_now) reads_done++;
      @(posedge clk); #1;
      if (reads_done == 10) c_rd = 1'b0;
      next_cycle();
    end
    chk_val("perf_10_reads", 64'(stall_cycles - perf_start), 64'(10 * (2 + RD_LAT)));
`endif

    // Randomized traffic from both requesters.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!(c_rd || c_wr) || core_done_now) new_core_req(1'b1);
      if (!d_req || dbg_done_now)           new_dbg_req(1'b1);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-port data memory behind the pipeline's MEM stage. It shares the memory between the core's load/store port and a debug/loader port. It drives registered memory commands and stalls the pipeline until the core's access completes. Core accesses have priority, and a starvation counter bounds how long debug can be locked out.

## Interface
Parameters:
- DATA_W, 32, data width
- ADDR_W, 9, word address width
- RD_LAT, 1, memory read latency in cycles after m_rd (legal 1..4)
- STARVE_MAX, 4, consecutive core grants allowed while debug waits (legal 1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- c_rd / c_wr  in  1 / 1  core load / store request, level, held until completion
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core store data
- c_stall  out  1  core must freeze MEM stage
- c_rdata  out  DATA_W  core load data
- d_req / d_we  in  1 / 1  debug request, level; d_we=1 selects write
- d_addr  in  ADDR_W  debug address
- d_wdata  in  DATA_W  debug write data
- d_gnt  out  1  one-cycle debug completion pulse
- d_rdata  out  DATA_W  debug read data
- m_rd / m_wr  out  1 / 1  registered memory strobes, one-cycle pulses
- m_addr  out  ADDR_W  registered memory address
- m_wdata  out  DATA_W  registered memory write data
- m_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after m_rd

## Operation
- States: IDLE, ISSUE, WAIT, DONE. A 2-bit latency counter is used in WAIT. An owner flag records core or debug.
- IDLE: pick a winner among the pending requests. Register the winner's addr, wdata and direction into m_* so that they appear next cycle. Then go to ISSUE. With no request pending, stay in IDLE.
- Arbitration: core wins if pending, unless starve_cnt==STARVE_MAX and d_req=1, in which case debug wins.
  - starve_cnt increments (saturating) on each core grant made while d_req=1.
  - starve_cnt clears on a debug grant, or in IDLE with d_req=0.
- Core c_rd and c_wr both high: treated as a write.
- ISSUE: exactly one of m_rd or m_wr is high.
  - Write: ISSUE is the completion cycle; next state is IDLE.
  - Read: next state is WAIT with the counter loaded to RD_LAT-1.
- WAIT: decrement the counter. When it reaches 0, capture m_rdata into the owner's rdata register and go to DONE.
- DONE: completion cycle for reads; next state is IDLE.
- Completion cycle, core owner: c_stall=0.
- Completion cycle, debug owner: d_gnt=1.
- c_stall = (c_rd|c_wr) & ~(core completion cycle). This is combinational from the inputs and state.
- c_rdata and d_rdata hold their last captured value until the next read by that requester.
- Requesters must hold request fields stable until completion. Changes mid-transaction are ignored because the fields are latched in IDLE.

## Timing
- Write, request seen in IDLE at cycle T:
  - m_wr at T+1
  - completion at T+1
  - next arbitration at T+2
- Read, request seen in IDLE at cycle T:
  - m_rd at T+1
  - capture at end of T+1+RD_LAT
  - completion at T+2+RD_LAT, with rdata valid from that cycle
  - next arbitration at T+3+RD_LAT
- Back-to-back core writes: one every 2 cycles.
- Reset (asserted at any time, including mid-transaction):
  - State goes to IDLE and starve_cnt to 0.
  - m_rd=m_wr=0; m_addr, m_wdata, c_rdata and d_rdata go to 0.
  - d_gnt=0.
  - Any in-flight access is abandoned with no completion.
- During reset, c_stall follows c_rd|c_wr.

## Configuration
- DMEM_ARB_PERF_EN defined:
  - Adds the output port stall_cycles (32 bits). It counts the cycles with c_stall=1.
  - The counter resets to 0 and wraps from 2^32-1 to 0.
- DMEM_ARB_PERF_EN undefined: the port and the counter are absent. Arbitration behaviour is identical.

## Test plan
- Core write addr 0x01A, data 0xDEADBEEF, RD_LAT=1 -> m_wr at T+1 with m_addr=0x01A; c_stall=1 at T only.
- Core read of 0x01A, RD_LAT=3 -> m_rd at T+1, c_stall high T..T+4, low at T+5 with c_rdata=0xDEADBEEF.
- Core and debug both requesting continuously, STARVE_MAX=4 -> grant order is C,C,C,C,D repeating; d_gnt pulses once per 5 transactions.
- Debug read of 0x100 alone -> d_gnt at T+2+RD_LAT with d_rdata equal to memory contents; c_stall stays 0.
- Reset asserted during WAIT of a core read -> all m_* outputs and c_rdata go to 0 immediately, no completion. After release, the held request restarts from IDLE.
- With DMEM_ARB_PERF_EN, 10 core reads at RD_LAT=1 issued back-to-back -> stall_cycles=30.
